// File: rtl/decoder_n2m_pipe.sv
// N-to-2^N line decoder with valid/ready handshake, registered output and a 2-deep skid buffer.
// Optional parity checking on {en,sel} is enabled by defining DEC_PARITY_EN.
module decoder_n2m_pipe #(
   parameter int SEL_W      = 2,
   parameter int ACTIVE_LOW = 0,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     en,
`ifdef DEC_PARITY_EN
   input  logic                     sel_par,
   output logic                     par_err,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [(1 << SEL_W)-1:0]  y,
   output logic [CNT_W-1:0]         txn_cnt
);

   localparam int OUT_W = 1 << SEL_W;
   localparam logic [OUT_W-1:0] IDLE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   function automatic logic parity_even(input logic [SEL_W:0] bits);
      parity_even = ^bits;
   endfunction

   function automatic logic [OUT_W-1:0] decode_word(input logic [SEL_W-1:0] s,
                                                    input logic e,
                                                    input logic bad);
      logic [OUT_W-1:0] hot;
      hot = {OUT_W{1'b0}};
      if (e && !bad) begin
         hot[s] = 1'b1;
      end else begin
         hot = {OUT_W{1'b0}};
      end
      decode_word = (ACTIVE_LOW != 0) ? ~hot : hot;
   endfunction

   logic [1:0]       state_r, state_s;
   logic [OUT_W-1:0] oreg_r, oreg_s;
   logic [OUT_W-1:0] sreg_r, sreg_s;
   logic             ov_r, ov_s;
   logic             in_ready_r;
   logic [CNT_W-1:0] cnt_r;
   logic             push_s, pop_s, bad_s;
   logic [OUT_W-1:0] word_s;

   // Handshake qualifiers and the decoded word of the incoming transaction
   always_comb begin
      push_s = in_valid & in_ready_r;
      pop_s  = ov_r & out_ready;
`ifdef DEC_PARITY_EN
      bad_s  = (sel_par != parity_even({en, sel}));
`else
      bad_s  = 1'b0;
`endif
      word_s = decode_word(sel, en, bad_s);
   end

   // Slot occupancy FSM: OREG drives y, SREG catches the word that arrives while OREG is stalled
   always_comb begin
      state_s = state_r;
      oreg_s  = oreg_r;
      ov_s    = ov_r;
      sreg_s  = sreg_r;
      case (state_r)
         ST_EMPTY: begin
            if (push_s) begin
               oreg_s  = word_s;
               ov_s    = 1'b1;
               state_s = ST_ONE;
            end else begin
               state_s = ST_EMPTY;
            end
         end
         ST_ONE: begin
            if (push_s && pop_s) begin
               oreg_s  = word_s;
               state_s = ST_ONE;
            end else if (push_s) begin
               sreg_s  = word_s;
               state_s = ST_FULL;
            end else if (pop_s) begin
               oreg_s  = IDLE;
               ov_s    = 1'b0;
               state_s = ST_EMPTY;
            end else begin
               state_s = ST_ONE;
            end
         end
         ST_FULL: begin
            if (pop_s) begin
               oreg_s  = sreg_r;
               sreg_s  = IDLE;
               state_s = ST_ONE;
            end else begin
               state_s = ST_FULL;
            end
         end
         default: begin
            state_s = ST_EMPTY;
            oreg_s  = IDLE;
            ov_s    = 1'b0;
            sreg_s  = IDLE;
         end
      endcase
   end

   // State, data slots, ready flag and pop counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_EMPTY;
         oreg_r     <= IDLE;
         ov_r       <= 1'b0;
         sreg_r     <= IDLE;
         in_ready_r <= 1'b0;
         cnt_r      <= {CNT_W{1'b0}};
      end else begin
         state_r    <= state_s;
         oreg_r     <= oreg_s;
         ov_r       <= ov_s;
         sreg_r     <= sreg_s;
         in_ready_r <= (state_s != ST_FULL);
         if (pop_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

`ifdef DEC_PARITY_EN
   logic serr_r, serr_s, perr_s, par_err_r;

   // Error flags follow their words; the pulse fires only when a flagged word lands in OREG
   always_comb begin
      serr_s = serr_r;
      perr_s = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (push_s) begin
               perr_s = bad_s;
            end else begin
               perr_s = 1'b0;
            end
         end
         ST_ONE: begin
            if (push_s && pop_s) begin
               perr_s = bad_s;
            end else if (push_s) begin
               serr_s = bad_s;
            end else begin
               perr_s = 1'b0;
            end
         end
         ST_FULL: begin
            if (pop_s) begin
               perr_s = serr_r;
               serr_s = 1'b0;
            end else begin
               perr_s = 1'b0;
            end
         end
         default: begin
            serr_s = 1'b0;
            perr_s = 1'b0;
         end
      endcase
   end

   // Parity error registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         serr_r    <= 1'b0;
         par_err_r <= 1'b0;
      end else begin
         serr_r    <= serr_s;
         par_err_r <= perr_s;
      end
   end

   assign par_err = par_err_r;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = ov_r;
   assign y         = oreg_r;
   assign txn_cnt   = cnt_r;

endmodule
